alu_arbiter: RTL and testbench

Shares one combinational `alu` instance between two requesters, such as the execute stage and a multi-cycle helper unit. Each requester hands over an (op, a, b) triple with a valid/ready handshake. The block arbitrates round-robin, drives the shared ALU from registered operands, captures the result, and returns it on a single response channel tagged with the requester id. It sits between the requesters and the `alu` operand_a_i/operand_b_i/alu_op_i/alu_data_o ports.

---
 rtl/alu_arbiter.sv | 91 +++++++++
 tb/tb_alu_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Each accepted request takes IDLE -> EXEC -> RESP and returns its result tagged with the owner id.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [1:0]          req_valid_i,
   output logic [1:0]          req_ready_o,
   input  logic [2*OP_W-1:0]   req_op_i,
   input  logic [2*DATA_W-1:0] req_a_i,
   input  logic [2*DATA_W-1:0] req_b_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic                rsp_id_o,
   output logic [DATA_W-1:0]   rsp_data_o,
   output logic [DATA_W-1:0]   alu_operand_a_o,
   output logic [DATA_W-1:0]   alu_operand_b_o,
   output logic [OP_W-1:0]     alu_op_o,
   input  logic [DATA_W-1:0]   alu_data_i
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state, state_nxt;
   logic                ptr, grant, id, accept;
   logic [OP_W-1:0]     op;
   logic [DATA_W-1:0]   a, b;

   // A lone requester wins outright; the pointer only breaks ties.
   always_comb begin
      grant = ptr;
      if (req_valid_i == 2'b01)
         grant = 1'b0;
      else if (req_valid_i == 2'b10)
         grant = 1'b1;
   end

   always_comb begin
      state_nxt   = state;
      accept      = 1'b0;
      req_ready_o = 2'b00;
      case (state)
         IDLE: begin
            if (!rst_i && (req_valid_i != 2'b00)) begin
               accept      = 1'b1;
               req_ready_o = grant ? 2'b10 : 2'b01;
               state_nxt   = EXEC;
            end
         end
         EXEC:    state_nxt = RESP;
         RESP:    if (rsp_ready_i) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         ptr        <= 1'b0;
         id         <= 1'b0;
         op         <= '0;
         a          <= '0;
         b          <= '0;
         rsp_data_o <= '0;
         rsp_id_o   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op <= req_op_i[OP_W*grant +: OP_W];
            a  <= req_a_i[DATA_W*grant +: DATA_W];
            b  <= req_b_i[DATA_W*grant +: DATA_W];
            id <= grant;
         end
         if (state == EXEC) begin
            rsp_data_o <= alu_data_i;
            rsp_id_o   <= id;
         end
         // Hand priority to the other requester once this result is consumed.
         if (state == RESP && rsp_ready_i)
            ptr <= ~id;
      end
   end

   assign rsp_valid_o     = (state == RESP);
   assign alu_operand_a_o = a;
   assign alu_operand_b_o = b;
   assign alu_op_o        = op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;

   localparam int DW = 32;
   localparam int OW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [2*OW-1:0] req_op;
   logic [2*DW-1:0] req_a, req_b;
   logic          rsp_valid, rsp_ready, rsp_id;
   logic [DW-1:0] rsp_data, alu_a, alu_b, alu_res;
   logic [OW-1:0] alu_op;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
      .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
      .alu_op_o(alu_op), .alu_data_i(alu_res)
   );

   // Reference ALU; unused codes return a marker so forwarding is visible.
   always_comb begin
      alu_res = 32'hDEADBEEF;
      case (alu_op)
         4'b0000: alu_res = alu_a + alu_b;
         4'b0001: alu_res = alu_a - alu_b;
         4'b0010: alu_res = {31'd0, $signed(alu_a) < $signed(alu_b)};
         4'b0011: alu_res = {31'd0, alu_a < alu_b};
         4'b0100: alu_res = alu_a ^ alu_b;
         4'b0101: alu_res = alu_a | alu_b;
         4'b0110: alu_res = alu_a & alu_b;
         4'b0111: alu_res = alu_a << alu_b[4:0];
         4'b1000: alu_res = alu_a >> alu_b[4:0];
         4'b1001: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         4'b1110: alu_res = alu_a + (alu_b << 12);
         4'b1111: alu_res = alu_b << 12;
         default: alu_res = 32'hDEADBEEF;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[OW*n +: OW] = op;
      req_a[DW*n +: DW]  = a;
      req_b[DW*n +: DW]  = b;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
      req_op = '0; req_a = '0; req_b = '0;

      // Reset: ready held low even with both valid
      step();
      req_valid = 2'b11;
      #1 chk("rst_ready", {30'd0, req_ready}, 32'd0);
      step();
      req_valid = 2'b00;
      rst = 1'b0;
      #1;
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);
      chk("rst_alu_op", {28'd0, alu_op}, 32'd0);

      // Single request: ADD 10,5
      step();
      set_req(0, 4'b0000, 32'd10, 32'd5);
      req_valid = 2'b01;
      #1 chk("single_ready", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b00;
      #1;
      chk("single_exec_op", {28'd0, alu_op}, 32'd0);
      chk("single_exec_a", alu_a, 32'd10);
      chk("single_exec_valid", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("single_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("single_rsp_id", {31'd0, rsp_id}, 32'd0);
      chk("single_rsp_data", rsp_data, 32'h0000000F);
      step();
      chk("single_idle_valid", {31'd0, rsp_valid}, 32'd0);

      // Contention from reset: SUB vs SLL
      do_reset();
      set_req(0, 4'b0001, 32'd10, 32'd5);
      set_req(1, 4'b0111, 32'd10, 32'd5);
      req_valid = 2'b11;
      #1 chk("cont_ready0", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b10;
      step();
      #1;
      chk("cont_rsp0_id", {31'd0, rsp_id}, 32'd0);
      chk("cont_rsp0_data", rsp_data, 32'h00000005);
      chk("cont_rsp_ready", {30'd0, req_ready}, 32'd0);
      step();
      chk("cont_ready1", {30'd0, req_ready}, 32'd2);
      step();
      req_valid = 2'b00;
      step();
      chk("cont_rsp1_id", {31'd0, rsp_id}, 32'd1);
      chk("cont_rsp1_data", rsp_data, 32'h00000140);
      step();
      req_valid = 2'b11;
      #1 chk("cont_pair2_ready", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b00;
      step();
      chk("cont_pair2_id", {31'd0, rsp_id}, 32'd0);
      step();

      // Alternation: both held valid; ADD 10,5=0xF and AND 12,10=0x8
      do_reset();
      set_req(0, 4'b0000, 32'd10, 32'd5);
      set_req(1, 4'b0110, 32'd12, 32'd10);
      req_valid = 2'b11;
      for (int c = 0; c < 18; c++) begin
         #1;
         chk($sformatf("alt_valid_c%0d", c), {31'd0, rsp_valid}, {31'd0, (c % 3) == 2});
         if (c % 3 == 0)
            chk($sformatf("alt_ready_c%0d", c), {30'd0, req_ready}, ((c / 3) % 2) ? 32'd2 : 32'd1);
         if (c % 3 == 2) begin
            chk($sformatf("alt_id_c%0d", c), {31'd0, rsp_id}, (c / 3) % 2);
            chk($sformatf("alt_data_c%0d", c), rsp_data, ((c / 3) % 2) ? 32'h8 : 32'hF);
         end
         step();
      end
      req_valid = 2'b00;

      // Backpressure: LUI via req1, consumer stalls 4 cycles while req0 waits
      set_req(1, 4'b1111, 32'd0, 32'd5);
      set_req(0, 4'b0000, 32'd10, 32'd5);
      req_valid = 2'b10;
      #1 chk("bp_ready", {30'd0, req_ready}, 32'd2);
      step();
      req_valid = 2'b01;
      rsp_ready = 1'b0;
      step();
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("bp_valid_%0d", c), {31'd0, rsp_valid}, 32'd1);
         chk($sformatf("bp_data_%0d", c), rsp_data, 32'h00005000);
         chk($sformatf("bp_ready_%0d", c), {30'd0, req_ready}, 32'd0);
         step();
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_hs_id", {31'd0, rsp_id}, 32'd1);
      chk("bp_hs_ready", {30'd0, req_ready}, 32'd0);
      step();
      chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_next_ready", {30'd0, req_ready}, 32'd1);
      step();
      req_valid = 2'b00;
      step();
      chk("bp_next_data", rsp_data, 32'h0000000F);
      step();

      // AUIPC via req1
      set_req(1, 4'b1110, 32'd10, 32'd5);
      req_valid = 2'b10;
      #1 chk("auipc_ready", {30'd0, req_ready}, 32'd2);
      step();
      req_valid = 2'b00;
      #1 chk("auipc_op", {28'd0, alu_op}, 32'hE);
      step();
      chk("auipc_id", {31'd0, rsp_id}, 32'd1);
      chk("auipc_data", rsp_data, 32'h0000500A);
      step();

      // Unused opcode forwarded untouched
      set_req(0, 4'b1010, 32'd1, 32'd2);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      #1 chk("unused_op", {28'd0, alu_op}, 32'hA);
      step();
      chk("unused_data", rsp_data, 32'hDEADBEEF);
      step();

      // Reset during EXEC drops the operation
      set_req(0, 4'b0000, 32'd10, 32'd5);
      req_valid = 2'b01;
      step();
      req_valid = 2'b00;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_rst_alu_a", alu_a, 32'd0);
      chk("mid_rst_alu_op", {28'd0, alu_op}, 32'd0);
      chk("mid_rst_data", rsp_data, 32'd0);
      set_req(1, 4'b0100, 32'd10, 32'd5);
      req_valid = 2'b10;
      #1 chk("mid_rst_ready", {30'd0, req_ready}, 32'd2);
      step();
      req_valid = 2'b00;
      #1 chk("mid_rst_exec_valid", {31'd0, rsp_valid}, 32'd0);
      step();
      chk("mid_rst_id", {31'd0, rsp_id}, 32'd1);
      chk("mid_rst_xor", rsp_data, 32'h0000000F);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
